// File: rtl/icache_fill_pkg.sv
// icache_fill shared types and constants.
// QSPI quad I/O fast-read refill engine for the instruction cache.
package icache_fill_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_REPLAY,
    S_DONE,
    S_GAP
  } state_t;

  localparam logic [7:0] QSPI_CMD_QIOR = 8'hEB;
  localparam int CMD_SCK  = 8;
  localparam int ADDR_SCK = 6;
  localparam int DATA_SCK = 8;

  // flash sends high nibble first, the cache wants low nibble first
  function automatic logic [2:0] nib_slot(input logic [2:0] i);
    return i ^ 3'd1;
  endfunction

endpackage

// File: rtl/qspi_nibble_phy.sv
// QSPI pin sequencer: sck phase, per-segment SCK counter,
// 1/4-bit shift register and sample strobe.
module qspi_nibble_phy (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        stop,
  input  logic [4:0]  load_cnt,
  input  logic [23:0] load_data,
  input  logic        load_quad,
  input  logic [3:0]  load_oe,
  input  logic [4:0]  load_oe_sck,
  output logic        sck,
  output logic [3:0]  io_out,
  output logic [3:0]  io_oe,
  output logic        sample_en,
  output logic        seg_done,
  output logic [4:0]  cnt
);

  logic        active;
  logic        ph;
  logic        quad;
  logic [23:0] sr;
  logic [3:0]  oe_mask;
  logic [4:0]  oe_left;
  logic [4:0]  cnt_q;
  logic [3:0]  drv;

  always_ff @(posedge clk) begin
    if (reset || stop) begin
      active  <= 1'b0;
      ph      <= 1'b0;
      quad    <= 1'b0;
      sr      <= '0;
      oe_mask <= '0;
      oe_left <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      active  <= 1'b1;
      ph      <= 1'b0;
      quad    <= load_quad;
      sr      <= load_data;
      oe_mask <= load_oe;
      oe_left <= load_oe_sck;
      cnt_q   <= load_cnt;
    end else if (active) begin
      ph <= ~ph;
      // end of phase B: advance to the next SCK
      if (ph) begin
        cnt_q <= cnt_q - 5'd1;
        sr    <= quad ? {sr[19:0], 4'h0} : {sr[22:0], 1'b0};
        if (oe_left != 5'd0)
          oe_left <= oe_left - 5'd1;
      end
    end
  end

  assign drv       = quad ? sr[23:20] : {3'b000, sr[23]};
  assign io_oe     = (oe_left != 5'd0) ? oe_mask : 4'h0;
  assign io_out    = drv & io_oe;
  assign sck       = ph;
  assign sample_en = active & ph;
  assign seg_done  = active & ph & (cnt_q == 5'd1);
  assign cnt       = cnt_q;

endmodule

// File: rtl/icache_fill.sv
// Instruction cache line refill from QSPI flash (0xEB),
// replayed to the cache as 8 gap-free nibble beats.
module icache_fill
  import icache_fill_pkg::*;
#(
  parameter int         PA          = 22,
  parameter int         LINE_LENGTH = 4,
  parameter int         DUMMY       = 6,
  parameter logic [7:0] MODE_BYTE   = 8'h00,
  parameter int         CS_IDLE     = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pull,
  input  logic [PA-3:0] tag,
  input  logic          fault,
  output logic [3:0]    dread,
  output logic          wstrobe_d,
  output logic          busy,
  output logic          qspi_cs_n,
  output logic          qspi_sck,
  output logic [3:0]    qspi_io_out,
  output logic [3:0]    qspi_io_oe,
  input  logic [3:0]    qspi_io_in
);

  localparam int NIBS = LINE_LENGTH * 2;

  state_t        state, state_n;
  logic [PA-3:0] tag_q;
  logic [31:0]   line_buf;
  logic [2:0]    rcnt;
  logic [4:0]    gcnt;
  logic          in_xfer;
  logic          abort;
  logic [23:0]   addr24;
  logic [2:0]    didx;
  logic [2:0]    slot;

  logic        phy_load;
  logic        phy_stop;
  logic [4:0]  phy_cnt_ld;
  logic [23:0] phy_data;
  logic        phy_quad;
  logic [3:0]  phy_oe;
  logic [4:0]  phy_oe_sck;
  logic        sample_en;
  logic        seg_done;
  logic [4:0]  phy_cnt;

  qspi_nibble_phy u_phy (
    .clk         (clk),
    .reset       (reset),
    .load        (phy_load),
    .stop        (phy_stop),
    .load_cnt    (phy_cnt_ld),
    .load_data   (phy_data),
    .load_quad   (phy_quad),
    .load_oe     (phy_oe),
    .load_oe_sck (phy_oe_sck),
    .sck         (qspi_sck),
    .io_out      (qspi_io_out),
    .io_oe       (qspi_io_oe),
    .sample_en   (sample_en),
    .seg_done    (seg_done),
    .cnt         (phy_cnt)
  );

  assign in_xfer = (state == S_CMD) || (state == S_ADDR) ||
                   (state == S_DUMMY) || (state == S_DATA);
  assign abort   = in_xfer && (!pull || (tag != tag_q));
  assign addr24  = 24'({tag_q, 2'b00});
  assign didx    = 3'(5'(DATA_SCK) - phy_cnt);
  assign slot    = nib_slot(didx);

  always_comb begin
    state_n    = state;
    phy_load   = 1'b0;
    phy_stop   = 1'b0;
    phy_cnt_ld = '0;
    phy_data   = '0;
    phy_quad   = 1'b0;
    phy_oe     = '0;
    phy_oe_sck = '0;
    if (abort) begin
      state_n  = S_GAP;
      phy_stop = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pull && !fault) begin
            state_n    = S_CMD;
            phy_load   = 1'b1;
            phy_cnt_ld = 5'(CMD_SCK);
            phy_data   = {QSPI_CMD_QIOR, 16'h0000};
            phy_oe     = 4'b0001;
            phy_oe_sck = 5'(CMD_SCK);
          end
        end
        S_CMD: begin
          if (seg_done) begin
            state_n    = S_ADDR;
            phy_load   = 1'b1;
            phy_cnt_ld = 5'(ADDR_SCK);
            phy_data   = addr24;
            phy_quad   = 1'b1;
            phy_oe     = 4'hF;
            phy_oe_sck = 5'(ADDR_SCK);
          end
        end
        S_ADDR: begin
          if (seg_done) begin
            state_n    = S_DUMMY;
            phy_load   = 1'b1;
            phy_cnt_ld = 5'(DUMMY);
            phy_data   = {MODE_BYTE, 16'h0000};
            phy_quad   = 1'b1;
            phy_oe     = 4'hF;
            phy_oe_sck = 5'd2;
          end
        end
        S_DUMMY: begin
          if (seg_done) begin
            state_n    = S_DATA;
            phy_load   = 1'b1;
            phy_cnt_ld = 5'(DATA_SCK);
            phy_quad   = 1'b1;
          end
        end
        S_DATA: begin
          if (seg_done) begin
            state_n  = S_REPLAY;
            phy_stop = 1'b1;
          end
        end
        S_REPLAY: begin
          if (rcnt == 3'(NIBS - 1))
            state_n = S_DONE;
        end
        S_DONE: state_n = S_GAP;
        S_GAP: begin
          if (gcnt == 5'(CS_IDLE - 1))
            state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      tag_q    <= '0;
      line_buf <= '0;
      rcnt     <= '0;
      gcnt     <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && state_n == S_CMD)
        tag_q <= tag;
      if (abort)
        line_buf <= '0;
      else if (state == S_DATA && sample_en)
        line_buf[4*slot +: 4] <= qspi_io_in;
      rcnt <= (state == S_REPLAY) ? rcnt + 3'd1 : 3'd0;
      gcnt <= (state == S_GAP) ? gcnt + 5'd1 : 5'd0;
    end
  end

  assign busy      = (state != S_IDLE);
  assign wstrobe_d = (state == S_REPLAY);
  assign dread     = wstrobe_d ? line_buf[4*rcnt +: 4] : 4'h0;
  assign qspi_cs_n = !in_xfer;

endmodule

// File: tb/tb_icache_fill.sv
// Scoreboard bench for icache_fill with a behavioural
// QSPI flash and a nibble-write cache model.
module tb_icache_fill;

  logic        clk = 1'b0;
  logic        reset;
  logic        pull;
  logic        fault;
  logic [19:0] tag;
  logic [3:0]  dread;
  logic        wstrobe_d;
  logic        busy;
  logic        qspi_cs_n;
  logic        qspi_sck;
  logic [3:0]  qspi_io_out;
  logic [3:0]  qspi_io_oe;
  logic [3:0]  qspi_io_in;

  int vecs = 0;
  int miss = 0;
  int n = 0;
  int nstrobe = 0;
  int beat = 0;
  logic [31:0] cache_line = '0;

  logic [3:0]  exp_q[$];
  logic [23:0] addr_q[$];

  int          k = 0;
  logic [7:0]  fcmd;
  logic [23:0] faddr;
  logic [7:0]  fmode;
  logic [7:0]  fbyte;

  icache_fill dut (
    .clk         (clk),
    .reset       (reset),
    .pull        (pull),
    .tag         (tag),
    .fault       (fault),
    .dread       (dread),
    .wstrobe_d   (wstrobe_d),
    .busy        (busy),
    .qspi_cs_n   (qspi_cs_n),
    .qspi_sck    (qspi_sck),
    .qspi_io_out (qspi_io_out),
    .qspi_io_oe  (qspi_io_oe),
    .qspi_io_in  (qspi_io_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    n++;
  endtask

  function automatic logic [7:0] mem(input logic [23:0] a);
    case (a)
      24'h000104: return 8'h12;
      24'h000105: return 8'h34;
      24'h000106: return 8'h56;
      24'h000107: return 8'h78;
      24'h000108: return 8'h9A;
      24'h000109: return 8'hBC;
      24'h00010A: return 8'hDE;
      24'h00010B: return 8'hF0;
      default:    return 8'hFF;
    endcase
  endfunction

  // flash model: captures the header, serves data nibbles
  always @(negedge clk) begin
    if (qspi_cs_n !== 1'b0) begin
      k = 0;
      qspi_io_in = 4'h0;
      fcmd = '0;
      faddr = '0;
      fmode = '0;
    end else if (qspi_sck) begin
      k++;
      if (k <= 8)
        fcmd = {fcmd[6:0], qspi_io_out[0]};
      else if (k <= 14)
        faddr = {faddr[19:0], qspi_io_out};
      else if (k <= 16)
        fmode = {fmode[3:0], qspi_io_out};
      if (k == 1) chk("cmd_oe", 32'(qspi_io_oe), 32'h1);
      if (k == 8) chk("cmd", 32'(fcmd), 32'hEB);
      if (k == 9) chk("addr_oe", 32'(qspi_io_oe), 32'hF);
      if (k == 14) begin
        if (addr_q.size() == 0) begin
          vecs++;
          miss++;
          $display("FAIL addr: got %h expected none", faddr);
        end else
          chk("addr", 32'(faddr), 32'(addr_q.pop_front()));
      end
      if (k == 16) chk("mode", 32'(fmode), 32'h00);
      if (k == 17 || k == 21) chk("rx_oe", 32'(qspi_io_oe), 32'h0);
      if (k >= 21 && k <= 28) begin
        fbyte = mem(faddr + 24'((k - 21) / 2));
        qspi_io_in = ((k - 21) % 2 == 0) ? fbyte[7:4] : fbyte[3:0];
      end
    end
  end

  // monitor: every strobe pops one expected nibble
  always @(negedge clk) begin
    if (reset)
      beat = 0;
    else if (wstrobe_d) begin
      nstrobe++;
      if (exp_q.size() == 0) begin
        vecs++;
        miss++;
        $display("FAIL beat: got strobe %h expected none", dread);
      end else
        chk("beat", 32'(dread), 32'(exp_q.pop_front()));
      cache_line[4*beat +: 4] = dread;
      beat = (beat + 1) % 8;
    end
  end

  task automatic start_fill(input logic [19:0] t, input logic [23:0] a,
                            input logic [31:0] nibs, input int npush);
    addr_q.push_back(a);
    for (int i = 0; i < npush; i++)
      exp_q.push_back(nibs[4*i +: 4]);
    tag = t;
    pull = 1'b1;
    fault = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    chk("start", {30'h0, qspi_cs_n, busy}, 32'h1);
    while (!wstrobe_d && n < 100) tick();
    chk("latency", n, 56);
  endtask

  task automatic finish_fill();
    repeat (7) tick();
    pull = 1'b0;
    while (busy && n < 200) tick();
    chk("total", n, 67);
  endtask

  task automatic gap_check(input string name);
    int g;
    g = 0;
    chk(name, {25'h0, qspi_cs_n, qspi_io_oe, qspi_sck, busy},
        {25'h0, 1'b1, 4'h0, 1'b0, 1'b1});
    while (busy && g < 20) begin
      g++;
      tick();
    end
    chk("gap_len", g, 2);
  endtask

  initial begin
    int bad;
    int s0;
    reset = 1'b1;
    pull = 1'b0;
    fault = 1'b0;
    tag = '0;
    qspi_io_in = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state",
        {19'h0, qspi_cs_n, qspi_sck, qspi_io_oe, qspi_io_out,
         wstrobe_d, dread, busy},
        {19'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0});
    reset = 1'b0;

    start_fill(20'h00041, 24'h000104, 32'h78563412, 8);
    finish_fill();
    chk("hit_104", 32'(cache_line[15:0]), 32'h3412);
    chk("hit_106", 32'(cache_line[31:16]), 32'h7856);

    fault = 1'b1;
    pull = 1'b1;
    tag = 20'h00041;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!qspi_cs_n || busy) bad++;
    end
    chk("fault_hold", bad, 0);
    start_fill(20'h00041, 24'h000104, 32'h78563412, 8);
    finish_fill();

    s0 = nstrobe;
    tag = 20'h00041;
    pull = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    repeat (20) tick();
    pull = 1'b0;
    tick();
    gap_check("abort_addr");
    repeat (4) tick();
    chk("abort_no_strobe", nstrobe, s0);

    addr_q.push_back(24'h000104);
    tag = 20'h00041;
    pull = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    repeat (45) tick();
    tag = 20'h00042;
    tick();
    gap_check("abort_data");
    chk("tagchg_no_strobe", nstrobe, s0);
    start_fill(20'h00042, 24'h000108, 32'hF0DEBC9A, 8);
    finish_fill();
    chk("new_line", cache_line, 32'hF0DEBC9A);

    start_fill(20'h00041, 24'h000104, 32'h78563412, 8);
    repeat (8) tick();
    tag = 20'h00042;
    addr_q.push_back(24'h000108);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] w;
      w = 32'hF0DEBC9A;
      exp_q.push_back(w[4*i +: 4]);
    end
    while (qspi_cs_n && n < 200) tick();
    chk("b2b_restart", n, 68);
    while (!wstrobe_d && n < 300) tick();
    chk("b2b_latency", n, 124);
    repeat (7) tick();
    pull = 1'b0;
    while (busy && n < 400) tick();
    chk("b2b_total", n, 135);

    start_fill(20'h00041, 24'h000104, 32'h78563412, 4);
    repeat (3) tick();
    #1;
    reset = 1'b1;
    pull = 1'b0;
    s0 = nstrobe;
    @(negedge clk);
    chk("reset_replay", {29'h0, wstrobe_d, qspi_cs_n, busy}, 32'h2);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset_no_strobe", nstrobe, s0);
    chk("queues_empty", exp_q.size() + addr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/icache_fill.md
Name: icache_fill

Overview:
- Refill engine directly upstream of the instruction cache.
- When the cache raises pull for a tag, this block reads one 4-byte line from external quad-SPI flash (command 0xEB, quad I/O fast read).
- It reorders the received nibbles into cache order, then drives the cache's nibble write port: 8 consecutive dread/wstrobe_d beats.
- Sole master of the QSPI pins.

Parameters:
PA, 22, physical address width; PA<=24.
LINE_LENGTH, 4, line size in bytes; only 4 is supported (8 nibbles).
DUMMY, 6, SCK cycles between address and data, including 2 mode cycles; DUMMY>=2.
MODE_BYTE, 8'h00, mode byte driven during the first 2 dummy SCKs.
CS_IDLE, 2, minimum clk cycles with qspi_cs_n high between transactions.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
pull  in  1  cache miss request
tag  in  PA-2  line address from the cache (paddr[PA-1:2])
fault  in  1  translation fault; blocks starting a fill
dread  out  4  nibble to the cache
wstrobe_d  out  1  nibble write strobe to the cache
busy  out  1  transaction in progress (any state except IDLE)
qspi_cs_n  out  1  flash chip select
qspi_sck  out  1  flash clock, SPI mode 0, clk/2
qspi_io_out  out  4  IO drive value
qspi_io_oe  out  4  IO output enable
qspi_io_in  in  4  IO sampled value

Behaviour:
- Reset values:
  - qspi_cs_n=1, qspi_sck=0, qspi_io_oe=0, qspi_io_out=0
  - wstrobe_d=0, dread=0, busy=0
  - state=IDLE
- Reset mid-transaction takes effect the next edge; no further strobes are issued.
- SPI timing: one SPI cycle = 2 clk.
  - Phase A: sck=0; outputs update at the start of this phase.
  - Phase B: sck=1.
  - qspi_io_in is sampled on the clk edge ending phase B.
- States: IDLE, CMD, ADDR, DUMMY, DATA, REPLAY, DONE, GAP.
- IDLE:
  - pull=1 && fault=0 at an edge: latch tag into tag_q, cs_n=0, go to CMD.
  - fault=1 holds the block in IDLE.
- CMD: 8 SCK. 0xEB MSB-first on IO0; oe=4'b0001.
- ADDR: 6 SCK. Quad, oe=4'hF. 24-bit address {zeros, tag_q, 2'b00}, high nibble first.
- DUMMY: DUMMY SCK.
  - First 2 SCK drive MODE_BYTE nibbles (high first), oe=4'hF.
  - Remaining SCK: oe=0.
- DATA: 8 SCK, oe=0.
  - Received nibble i (0..7) is stored at line_buf[4*(i^1)+:4].
  - Flash sends the high nibble of each byte first; the cache wants the low nibble first.
- Leaving DATA: cs_n=1, sck=0, go to REPLAY.
- REPLAY: exactly 8 consecutive cycles.
  - wstrobe_d=1, dread=line_buf[4*k+:4] for k=0..7.
  - The cache's internal counter requires the beats to be gap-free.
  - Not abortable except by reset.
- DONE: 1 cycle with wstrobe_d=0. The cache's hit rises here; pull is ignored.
- GAP: CS_IDLE cycles with cs_n=1, then IDLE. pull is ignored.
- Latency: first wstrobe_d is 2*(22+DUMMY) clk after the edge sampling pull (56 at default). Fill-to-IDLE total is 56+8+1+CS_IDLE.
- Abort rule: in CMD..DATA, if pull=0 or tag!=tag_q at any edge:
  - cs_n=1, sck=0, oe=0
  - go to GAP; no strobes issued
  - line_buf contents are discarded.
- The core must hold paddr stable from pull until hit. The cache indexes with live paddr during the write beats.
- busy=1 in every state except IDLE.
- At no time are qspi_io_oe and sampling active on the same IO.

Decomposition:
- Package icache_fill_pkg holds:
  - state enum
  - QSPI_CMD_QIOR=8'hEB
  - function nib_slot(i)=i^1
  - SPI cycle-count constants CMD_SCK=8, ADDR_SCK=6, DATA_SCK=8
- Sub-module qspi_nibble_phy:
  - owns the sck phase toggle, the per-state SCK down-counter, and the 1/4-bit output shift register
  - generates sample_en pulses
- icache_fill keeps the FSM, tag_q, line_buf and the replay counter.

Test Plan:
- Basic fill, tag=20'h00041, flash bytes at 0x000104 = 12 34 56 78:
  - IO0 carries 0xEB.
  - Address nibbles are 0,0,0,1,0,4; mode nibbles are 0,0.
  - 56 clk after pull, dread is 2,1,4,3,6,5,8,7 on 8 consecutive wstrobe_d cycles.
  - The cache then hits and reads 0x3412 at paddr 0x104 and 0x7856 at 0x106.
- fault=1 with pull=1 for 20 cycles: cs_n stays 1, busy=0. After fault drops, the fill starts on the next edge.
- Abort: pull drops during ADDR.
  - Next cycle cs_n=1 and oe=0.
  - No wstrobe_d.
  - busy=1 for CS_IDLE cycles, then 0.
- Tag change during DATA: same abort response, and line_buf is not replayed. A new pull after GAP fetches the new address.
- Reset asserted mid-REPLAY at beat 3:
  - Next cycle wstrobe_d=0, cs_n=1, state IDLE.
  - Cache r_valid is cleared by the same reset.
- Back-to-back misses (pull stays high for a second tag right after DONE): cs_n stays high for exactly CS_IDLE cycles, then the second CMD begins.
